// File: rtl/continuous_monitoring_system_pkg.sv
// Shared widths, control-register map and trace FSM encoding for the
// continuous monitoring system.
package continuous_monitoring_system_pkg;

  localparam int unsigned XLEN              = 64;
  localparam int unsigned CTRL_ADDR_WIDTH   = 8;
  localparam int unsigned CTRL_DATA_WIDTH   = 64;
  localparam int unsigned CLK_COUNTER_WIDTH = 64;

  localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

  typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
    ADDR_START_ENABLE         = 8'h00,
    ADDR_START_ADDR           = 8'h01,
    ADDR_END_ENABLE           = 8'h02,
    ADDR_END_ADDR             = 8'h03,
    ADDR_RANGE_LOWER_ENABLE   = 8'h04,
    ADDR_RANGE_LOWER          = 8'h05,
    ADDR_RANGE_UPPER_ENABLE   = 8'h06,
    ADDR_RANGE_UPPER          = 8'h07,
    ADDR_WFI_STOPPED          = 8'h08,
    ADDR_CLK_COUNTER          = 8'h09,
    ADDR_LAST_WRITE_TIMESTAMP = 8'h0A
  } ctrl_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACING,
    ST_STOPPED
  } trace_state_t;

endpackage

// File: rtl/cms_trace_ctrl_if.sv
// Control-register bus between a configuring master and the trace controller.
interface cms_trace_ctrl_if
  import continuous_monitoring_system_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CTRL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CTRL_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] ctrl_addr;
  logic [DATA_WIDTH-1:0] ctrl_wdata;
  logic                  ctrl_write_enable;
  logic [DATA_WIDTH-1:0] ctrl_rdata;

  modport master (
    output ctrl_addr, ctrl_wdata, ctrl_write_enable,
    input  ctrl_rdata
  );

  modport slave (
    input  ctrl_addr, ctrl_wdata, ctrl_write_enable,
    output ctrl_rdata
  );
endinterface

// File: rtl/cms_addr_range_check.sv
// Inclusive unsigned address window test; a disabled bound never excludes.
module cms_addr_range_check
  import continuous_monitoring_system_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = XLEN
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] lower,
  input  logic [ADDR_WIDTH-1:0] upper,
  input  logic                  lower_en,
  input  logic                  upper_en,
  output logic                  in_range
);
  assign in_range = (!lower_en || (pc >= lower)) && (!upper_en || (pc <= upper));
endmodule

// File: rtl/cms_trace_ctrl.sv
// Trace start/stop controller: trigger/range config registers, WFI stop,
// free-running cycle counter and timestamp of the last traced instruction.
module cms_trace_ctrl #(
  parameter int unsigned XLEN              = continuous_monitoring_system_pkg::XLEN,
  parameter int unsigned CTRL_ADDR_WIDTH   = continuous_monitoring_system_pkg::CTRL_ADDR_WIDTH,
  parameter int unsigned CTRL_DATA_WIDTH   = continuous_monitoring_system_pkg::CTRL_DATA_WIDTH,
  parameter int unsigned CLK_COUNTER_WIDTH = continuous_monitoring_system_pkg::CLK_COUNTER_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  cms_trace_ctrl_if.slave              ctrl,
  input  logic                         pc_valid,
  input  logic [XLEN-1:0]              pc,
  input  logic [31:0]                  instr,
  output logic                         trace_valid,
  output logic                         wfi_stopped,
  output logic [CLK_COUNTER_WIDTH-1:0] clk_counter,
  output logic [CLK_COUNTER_WIDTH-1:0] last_write_timestamp
);
  import continuous_monitoring_system_pkg::*;

  trace_state_t         state;
  logic                 start_en, end_en, lower_en, upper_en;
  logic [XLEN-1:0]      start_addr, end_addr, lower, upper;
  logic                 in_range, is_wfi, start_hit, end_hit, trace_fire;
  logic                 wr_start_en, wr_start_addr, wr_end_en, wr_end_addr;
  logic                 wr_lower_en, wr_lower, wr_upper_en, wr_upper;
  logic                 wr_wfi, wr_counter, wr_timestamp;
  logic [CTRL_DATA_WIDTH-1:0] rdata_next;

  cms_addr_range_check #(.ADDR_WIDTH(XLEN)) u_range (
    .pc       (pc),
    .lower    (lower),
    .upper    (upper),
    .lower_en (lower_en),
    .upper_en (upper_en),
    .in_range (in_range)
  );

  always_comb begin
    wr_start_en  = 1'b0;
    wr_start_addr = 1'b0;
    wr_end_en    = 1'b0;
    wr_end_addr  = 1'b0;
    wr_lower_en  = 1'b0;
    wr_lower     = 1'b0;
    wr_upper_en  = 1'b0;
    wr_upper     = 1'b0;
    wr_wfi       = 1'b0;
    wr_counter   = 1'b0;
    wr_timestamp = 1'b0;
    if (ctrl.ctrl_write_enable) begin
      case (ctrl.ctrl_addr)
        CTRL_ADDR_WIDTH'(ADDR_START_ENABLE):         wr_start_en   = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_START_ADDR):           wr_start_addr = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_END_ENABLE):           wr_end_en     = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_END_ADDR):             wr_end_addr   = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_RANGE_LOWER_ENABLE):   wr_lower_en   = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_RANGE_LOWER):          wr_lower      = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_RANGE_UPPER_ENABLE):   wr_upper_en   = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_RANGE_UPPER):          wr_upper      = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_WFI_STOPPED):          wr_wfi        = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_CLK_COUNTER):          wr_counter    = 1'b1;
        CTRL_ADDR_WIDTH'(ADDR_LAST_WRITE_TIMESTAMP): wr_timestamp  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_next = '0;
    case (ctrl.ctrl_addr)
      CTRL_ADDR_WIDTH'(ADDR_START_ENABLE):         rdata_next = CTRL_DATA_WIDTH'(start_en);
      CTRL_ADDR_WIDTH'(ADDR_START_ADDR):           rdata_next = CTRL_DATA_WIDTH'(start_addr);
      CTRL_ADDR_WIDTH'(ADDR_END_ENABLE):           rdata_next = CTRL_DATA_WIDTH'(end_en);
      CTRL_ADDR_WIDTH'(ADDR_END_ADDR):             rdata_next = CTRL_DATA_WIDTH'(end_addr);
      CTRL_ADDR_WIDTH'(ADDR_RANGE_LOWER_ENABLE):   rdata_next = CTRL_DATA_WIDTH'(lower_en);
      CTRL_ADDR_WIDTH'(ADDR_RANGE_LOWER):          rdata_next = CTRL_DATA_WIDTH'(lower);
      CTRL_ADDR_WIDTH'(ADDR_RANGE_UPPER_ENABLE):   rdata_next = CTRL_DATA_WIDTH'(upper_en);
      CTRL_ADDR_WIDTH'(ADDR_RANGE_UPPER):          rdata_next = CTRL_DATA_WIDTH'(upper);
      CTRL_ADDR_WIDTH'(ADDR_WFI_STOPPED):          rdata_next = CTRL_DATA_WIDTH'(wfi_stopped);
      CTRL_ADDR_WIDTH'(ADDR_CLK_COUNTER):          rdata_next = CTRL_DATA_WIDTH'(clk_counter);
      CTRL_ADDR_WIDTH'(ADDR_LAST_WRITE_TIMESTAMP): rdata_next = CTRL_DATA_WIDTH'(last_write_timestamp);
      default: ;
    endcase
  end

  // WFI beats any trigger match; the end trigger is only looked at once tracing.
  always_comb begin
    is_wfi     = (instr == WFI_INSTRUCTION);
    start_hit  = !start_en || (pc == start_addr);
    end_hit    = end_en && (pc == end_addr);
    trace_fire = pc_valid && in_range && !is_wfi && !wr_wfi &&
                 ((state == ST_TRACING) || ((state == ST_IDLE) && start_hit));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_en   <= 1'b0;
      end_en     <= 1'b0;
      lower_en   <= 1'b0;
      upper_en   <= 1'b0;
      start_addr <= '0;
      end_addr   <= '0;
      lower      <= '0;
      upper      <= '0;
      ctrl.ctrl_rdata <= '0;
    end else begin
      if (wr_start_en)   start_en   <= ctrl.ctrl_wdata[0];
      if (wr_start_addr) start_addr <= XLEN'(ctrl.ctrl_wdata);
      if (wr_end_en)     end_en     <= ctrl.ctrl_wdata[0];
      if (wr_end_addr)   end_addr   <= XLEN'(ctrl.ctrl_wdata);
      if (wr_lower_en)   lower_en   <= ctrl.ctrl_wdata[0];
      if (wr_lower)      lower      <= XLEN'(ctrl.ctrl_wdata);
      if (wr_upper_en)   upper_en   <= ctrl.ctrl_wdata[0];
      if (wr_upper)      upper      <= XLEN'(ctrl.ctrl_wdata);
      ctrl.ctrl_rdata <= rdata_next;
    end
  end

  // A software write to WFI_STOPPED overrides any pc-driven transition that cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      trace_valid <= 1'b0;
      wfi_stopped <= 1'b0;
    end else begin
      trace_valid <= trace_fire;
      if (wr_wfi) begin
        wfi_stopped <= ctrl.ctrl_wdata[0];
        if (ctrl.ctrl_wdata[0])         state <= ST_STOPPED;
        else if (state == ST_STOPPED)   state <= ST_IDLE;
      end else if (pc_valid) begin
        case (state)
          ST_IDLE: begin
            if (is_wfi) begin
              wfi_stopped <= 1'b1;
              state       <= ST_STOPPED;
            end else if (start_hit) begin
              state <= ST_TRACING;
            end
          end
          ST_TRACING: begin
            if (is_wfi) begin
              wfi_stopped <= 1'b1;
              state       <= ST_STOPPED;
            end else if (end_hit) begin
              state <= ST_STOPPED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_counter          <= '0;
      last_write_timestamp <= '0;
    end else begin
      if (wr_counter) clk_counter <= CLK_COUNTER_WIDTH'(ctrl.ctrl_wdata);
      else            clk_counter <= clk_counter + CLK_COUNTER_WIDTH'(1);
      if (trace_fire)        last_write_timestamp <= clk_counter;
      else if (wr_timestamp) last_write_timestamp <= CLK_COUNTER_WIDTH'(ctrl.ctrl_wdata);
    end
  end

endmodule

// File: tb/tb_cms_trace_ctrl.sv
// Directed vector bench for cms_trace_ctrl: table of per-cycle stimulus with
// expected outputs, plus hand sequences for counter, timestamp and reset.
module tb_cms_trace_ctrl;
  import continuous_monitoring_system_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        pv;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exp_tv;
    logic        exp_wfi;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        trace_valid, wfi_stopped;
  logic [63:0] clk_counter, last_write_timestamp;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  cms_trace_ctrl_if bus ();

  cms_trace_ctrl #(
    .XLEN              (XLEN),
    .CTRL_ADDR_WIDTH   (CTRL_ADDR_WIDTH),
    .CTRL_DATA_WIDTH   (CTRL_DATA_WIDTH),
    .CLK_COUNTER_WIDTH (CLK_COUNTER_WIDTH)
  ) dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .ctrl                 (bus),
    .pc_valid             (pc_valid),
    .pc                   (pc),
    .instr                (instr),
    .trace_valid          (trace_valid),
    .wfi_stopped          (wfi_stopped),
    .clk_counter          (clk_counter),
    .last_write_timestamp (last_write_timestamp)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic we, input logic [7:0] a, input logic [63:0] d,
                              input logic pv, input logic [63:0] p, input logic [31:0] ins,
                              input logic tv, input logic wf, input logic chk, input logic [63:0] rd);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.pv = pv; v.pc = p; v.instr = ins;
    v.exp_tv = tv; v.exp_wfi = wf; v.chk_rd = chk; v.exp_rd = rd;
    return v;
  endfunction

  function automatic vec_t fw(input logic [7:0] a, input logic [63:0] d, input logic tv, input logic wf);
    return mk(1'b1, a, d, 1'b0, 64'h0, NOP, tv, wf, 1'b0, 64'h0);
  endfunction

  function automatic vec_t fp(input logic [63:0] p, input logic [31:0] ins, input logic tv, input logic wf);
    return mk(1'b0, 8'h00, 64'h0, 1'b1, p, ins, tv, wf, 1'b0, 64'h0);
  endfunction

  function automatic vec_t fr(input logic [7:0] a, input logic [63:0] rd, input logic tv, input logic wf);
    return mk(1'b0, a, 64'h0, 1'b0, 64'h0, NOP, tv, wf, 1'b1, rd);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] a, input logic [63:0] d,
                       input logic pv, input logic [63:0] p, input logic [31:0] ins);
    bus.ctrl_write_enable = we;
    bus.ctrl_addr         = a;
    bus.ctrl_wdata        = d;
    pc_valid              = pv;
    pc                    = p;
    instr                 = ins;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge CLK);
    drive(v.we, v.addr, v.wdata, v.pv, v.pc, v.instr);
    @(posedge CLK);
    #1;
    check({tag, "_trace_valid"}, 64'(trace_valid), 64'(v.exp_tv));
    check({tag, "_wfi_stopped"}, 64'(wfi_stopped), 64'(v.exp_wfi));
    if (v.chk_rd) check({tag, "_rdata"}, bus.ctrl_rdata, v.exp_rd);
  endtask

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 8'h00, 64'h0, 1'b0, 64'h0, NOP);
    #1;
    check("rst_trace_valid", 64'(trace_valid), 64'h0);
    check("rst_wfi_stopped", 64'(wfi_stopped), 64'h0);
    check("rst_clk_counter", clk_counter, 64'h0);
    check("rst_timestamp", last_write_timestamp, 64'h0);
    check("rst_rdata", bus.ctrl_rdata, 64'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // start trigger at 0x1000
    vq.push_back(fw(ADDR_START_ENABLE, 64'h1, 0, 0));
    vq.push_back(fw(ADDR_START_ADDR, 64'h1000, 0, 0));
    vq.push_back(fp(64'h0FFC, NOP, 0, 0));
    vq.push_back(fp(64'h1000, NOP, 1, 0));
    vq.push_back(fp(64'h1004, NOP, 1, 0));
    // end trigger at 0x2000, inclusive
    vq.push_back(fw(ADDR_END_ENABLE, 64'h1, 0, 0));
    vq.push_back(fw(ADDR_END_ADDR, 64'h2000, 0, 0));
    vq.push_back(fp(64'h2000, NOP, 1, 0));
    vq.push_back(fp(64'h2004, NOP, 0, 0));
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h0, 0, 0));
    // WFI wins over start match in IDLE
    vq.push_back(fp(64'h1000, WFI_INSTRUCTION, 0, 1));
    vq.push_back(fp(64'h1000, NOP, 0, 1));
    vq.push_back(fr(ADDR_WFI_STOPPED, 64'h1, 0, 1));
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h0, 0, 0));
    // WFI while tracing
    vq.push_back(fp(64'h1000, NOP, 1, 0));
    vq.push_back(fp(64'h1234, WFI_INSTRUCTION, 0, 1));
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h0, 0, 0));
    // start == end on same pc: IDLE only starts, then end fires in TRACING
    vq.push_back(fw(ADDR_END_ADDR, 64'h1000, 0, 0));
    vq.push_back(fp(64'h1000, NOP, 1, 0));
    vq.push_back(fp(64'h1000, NOP, 1, 0));
    vq.push_back(fp(64'h1004, NOP, 0, 0));
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h0, 0, 0));
    // software-forced stop
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h1, 0, 1));
    vq.push_back(fp(64'h1000, NOP, 0, 1));
    vq.push_back(fw(ADDR_WFI_STOPPED, 64'h0, 0, 0));
    // range window 0x100..0x1FF, triggers disabled
    vq.push_back(fw(ADDR_START_ENABLE, 64'h0, 0, 0));
    vq.push_back(fw(ADDR_END_ENABLE, 64'h0, 0, 0));
    vq.push_back(fw(ADDR_RANGE_LOWER, 64'h100, 0, 0));
    vq.push_back(fw(ADDR_RANGE_LOWER_ENABLE, 64'h1, 0, 0));
    vq.push_back(fw(ADDR_RANGE_UPPER, 64'h1FF, 0, 0));
    vq.push_back(fw(ADDR_RANGE_UPPER_ENABLE, 64'h1, 0, 0));
    vq.push_back(fp(64'h0FF, NOP, 0, 0));
    vq.push_back(fp(64'h100, NOP, 1, 0));
    vq.push_back(fp(64'h1FF, NOP, 1, 0));
    vq.push_back(fp(64'h200, NOP, 0, 0));
    // register readback and unmapped space
    vq.push_back(fr(ADDR_RANGE_LOWER, 64'h100, 0, 0));
    vq.push_back(fr(ADDR_RANGE_UPPER, 64'h1FF, 0, 0));
    vq.push_back(fr(ADDR_RANGE_LOWER_ENABLE, 64'h1, 0, 0));
    vq.push_back(mk(1'b1, 8'h55, 64'hDEAD, 1'b0, 64'h0, NOP, 0, 0, 1'b1, 64'h0));
    vq.push_back(fr(8'h55, 64'h0, 0, 0));
    vq.push_back(fr(ADDR_END_ADDR, 64'h1000, 0, 0));
    vq.push_back(fr(ADDR_START_ADDR, 64'h1000, 0, 0));
    vq.push_back(fr(ADDR_START_ENABLE, 64'h0, 0, 0));

    foreach (vq[i]) apply(vq[i], $sformatf("v%0d", i));

    // counter load/wrap and timestamp capture (still TRACING, window 0x100..0x1FF)
    @(negedge CLK); drive(1'b1, ADDR_CLK_COUNTER, '1, 1'b0, 64'h0, NOP);
    @(posedge CLK); #1; check("cnt_load_ones", clk_counter, '1);
    @(negedge CLK); drive(1'b0, 8'h00, 64'h0, 1'b0, 64'h0, NOP);
    @(posedge CLK); #1; check("cnt_wrap", clk_counter, 64'h0);
    @(negedge CLK); drive(1'b1, ADDR_CLK_COUNTER, 64'h3, 1'b0, 64'h0, NOP);
    @(posedge CLK); #1; check("cnt_load3", clk_counter, 64'h3);
    @(negedge CLK); drive(1'b0, 8'h00, 64'h0, 1'b0, 64'h0, NOP);
    @(posedge CLK);
    @(posedge CLK); #1; check("cnt_5", clk_counter, 64'h5);
    @(negedge CLK); drive(1'b0, 8'h00, 64'h0, 1'b1, 64'h150, NOP);
    @(posedge CLK); #1;
    check("ts_trace_valid", 64'(trace_valid), 64'h1);
    check("ts_capture5", last_write_timestamp, 64'h5);
    check("cnt_6", clk_counter, 64'h6);
    @(negedge CLK); drive(1'b1, ADDR_LAST_WRITE_TIMESTAMP, 64'h77, 1'b1, 64'h150, NOP);
    @(posedge CLK); #1; check("ts_trace_wins", last_write_timestamp, 64'h6);
    @(negedge CLK); drive(1'b1, ADDR_LAST_WRITE_TIMESTAMP, 64'h77, 1'b0, 64'h0, NOP);
    @(posedge CLK); #1; check("ts_write", last_write_timestamp, 64'h77);
    @(negedge CLK); drive(1'b0, ADDR_LAST_WRITE_TIMESTAMP, 64'h0, 1'b0, 64'h0, NOP);
    @(posedge CLK); #1; check("ts_readback", bus.ctrl_rdata, 64'h77);

    // asynchronous reset in the middle of a trace
    @(negedge CLK); drive(1'b0, ADDR_RANGE_LOWER, 64'h0, 1'b1, 64'h150, NOP);
    @(posedge CLK); #1;
    check("pre_rst_trace_valid", 64'(trace_valid), 64'h1);
    check("pre_rst_rdata", bus.ctrl_rdata, 64'h100);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_trace_valid", 64'(trace_valid), 64'h0);
    check("async_rst_clk_counter", clk_counter, 64'h0);
    check("async_rst_timestamp", last_write_timestamp, 64'h0);
    check("async_rst_rdata", bus.ctrl_rdata, 64'h0);
    @(negedge CLK); drive(1'b0, 8'h00, 64'h0, 1'b0, 64'h0, NOP);
    @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    apply(fr(ADDR_RANGE_LOWER, 64'h0, 0, 0), "post_rst_lower");
    apply(fw(ADDR_START_ENABLE, 64'h1, 0, 0), "post_rst_start_en");
    apply(fp(64'h40, NOP, 0, 0), "post_rst_idle");
    apply(fp(64'h0, NOP, 1, 0), "post_rst_start_at_0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cms_trace_ctrl.md
CMS_TRACE_CTRL -- requirements
Module: cms_trace_ctrl

Interface
REQ-001 Parameter XLEN, 64, PC width.
REQ-002 Parameter CTRL_ADDR_WIDTH, 8, control address width.
REQ-003 Parameter CTRL_DATA_WIDTH, 64, control data width.
REQ-004 Parameter CLK_COUNTER_WIDTH, 64, cycle counter width.
REQ-005 CLK  input  1  sole clock; all state on rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 ctrl_addr  input  CTRL_ADDR_WIDTH  control register address (ctrl_addr_t encoding).
REQ-008 ctrl_wdata  input  CTRL_DATA_WIDTH  write data.
REQ-009 ctrl_write_enable  input  1  write strobe, one write per cycle.
REQ-010 ctrl_rdata  output  CTRL_DATA_WIDTH  registered read data for ctrl_addr.
REQ-011 pc_valid  input  1  retired-instruction strobe.
REQ-012 pc  input  XLEN  retired instruction address.
REQ-013 instr  input  32  retired instruction word.
REQ-014 trace_valid  output  1  registered: current retired instruction is to be traced.
REQ-015 wfi_stopped  output  1  sticky WFI stop flag.
REQ-016 clk_counter  output  CLK_COUNTER_WIDTH  free-running cycle count.
REQ-017 last_write_timestamp  output  CLK_COUNTER_WIDTH  clk_counter value at last trace_valid.

Function
REQ-018 Config registers: start/end trigger enable (bit 0) and address, range lower/upper enable (bit 0) and bound; written when ctrl_write_enable and ctrl_addr matches; new values take effect the following cycle.
REQ-019 Unmapped write addresses SHALL be ignored; unmapped reads SHALL return 0.
REQ-020 ctrl_rdata SHALL present the addressed register one cycle after ctrl_addr is sampled; enables read as zero-extended bit.
REQ-021 FSM states IDLE, TRACING, STOPPED.
REQ-022 IDLE->TRACING on pc_valid when start trigger disabled or pc == start address; the triggering instruction is traced.
REQ-023 TRACING->STOPPED on pc_valid with end trigger enabled and pc == end address; that instruction is traced (inclusive).
REQ-024 In IDLE or TRACING, pc_valid with instr == WFI_INSTRUCTION SHALL set wfi_stopped and go to STOPPED; the WFI is not traced; WFI has priority over start/end matches.
REQ-025 Start and end match on the same pc in IDLE: go TRACING only (end checked only in TRACING).
REQ-026 STOPPED->IDLE on a write to WFI_STOPPED with wdata bit 0 = 0, which also clears wfi_stopped; write of 1 forces wfi_stopped=1 and STOPPED.
REQ-027 In range = (lower disabled or pc >= lower) and (upper disabled or pc <= upper), unsigned, inclusive.
REQ-028 trace_valid next cycle = pc_valid and in range and (state==TRACING or entering TRACING) and not WFI.
REQ-029 clk_counter SHALL increment by 1 each cycle, wrapping to 0 after all-ones; a write to CLK_COUNTER loads wdata (write wins over increment).
REQ-030 When trace_valid is set, last_write_timestamp SHALL capture clk_counter of the same cycle pc_valid was sampled; writes to LAST_WRITE_TIMESTAMP load wdata, trace capture wins if simultaneous.

Reset
REQ-031 RST_N low SHALL immediately force: state IDLE, all enables 0, addresses/bounds 0, trace_valid 0, wfi_stopped 0, clk_counter 0, last_write_timestamp 0, ctrl_rdata 0; reset mid-trace discards state.

Structure
REQ-032 ctrl_addr_t, WFI_INSTRUCTION, XLEN, CTRL widths and CLK_COUNTER_WIDTH SHALL come from continuous_monitoring_system_pkg; the FSM state enum SHALL be added there.
REQ-033 Single sub-module cms_addr_range_check (pc, bounds, enables -> in_range) SHALL be used.

Verification
REQ-034 Start en, addr 0x1000; pc_valid pc 0x0FFC,0x1000,0x1004 -> trace_valid 0,1,1; state TRACING.
REQ-035 End en, addr 0x2000 while TRACING; pc 0x2000 then 0x2004 -> trace_valid 1 then 0; state STOPPED.
REQ-036 TRACING, instr 0x10500073 -> trace_valid 0, wfi_stopped 1; write WFI_STOPPED=0 -> IDLE, wfi_stopped 0.
REQ-037 Range lower 0x100 upper 0x1FF enabled, start disabled; pc 0xFF,0x100,0x1FF,0x200 -> 0,1,1,0.
REQ-038 Write CLK_COUNTER=all-ones -> next cycle 0; trace at counter 5 -> last_write_timestamp 5.
REQ-039 Assert RST_N low mid-TRACING -> all outputs 0 without clock edge; after release, IDLE.
